// File: rtl/sumador_serie.sv
// ---------------------------------------------------------------------------
// sumador_serie -- bit-serial adder, LSB first.
//
// Two N-bit operands are captured on an accepted start request and summed
// one bit per clock through a full adder built from two medio_sumador cells
// and an OR gate, with a carry flip-flop fed back between bits. The N-bit sum
// and the MSB carry-out are published together on the last bit edge, and a
// one-cycle completion pulse follows.
//
// Optional feature macro: SUMADOR_SERIE_RESTA_EN
//   When defined, an extra input 'resta' selects A - B (mod 2^N). In that
//   mode Cout = 1 means no borrow (A >= B). When undefined the port is
//   absent and the block only adds.
//
// Parameters:
//   N        operand/sum width in bits (1..32)
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   inicio   start request, honoured only while idle
//   A, B     operands, captured with an accepted inicio
//   resta    (macro only) subtract select, captured with an accepted inicio
//   S        registered sum, updated only at completion
//   Cout     registered carry-out of the MSB
//   ocupado  high while an operation is in progress (state not REPOSO)
//   fin      one-cycle completion pulse
// ---------------------------------------------------------------------------

// Half adder: the arithmetic cell reused by the serial datapath.
module medio_sumador (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Sum is the XOR, carry is the AND of the two input bits.
  assign s = a ^ b;
  assign c = a & b;

endmodule

module sumador_serie #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
`ifdef SUMADOR_SERIE_RESTA_EN
  input  logic         resta,
`endif
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         ocupado,
  output logic         fin
);

  // The counter must be able to hold the value N after the last bit.
  localparam int CW = (N < 2) ? 1 : $clog2(N + 1);

  localparam logic [1:0] REPOSO = 2'd0;
  localparam logic [1:0] SUMA   = 2'd1;
  localparam logic [1:0] FIN    = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  reg_a;
  logic [N-1:0]  reg_b;
  logic [N-1:0]  sum_reg;
  logic [N-1:0]  sum_next;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          resta_sel;

  logic          ha1_s;
  logic          ha1_c;
  logic          fa_s;
  logic          ha2_c;
  logic          fa_c;

  // Subtraction is two's complement: invert B and inject a carry-in of 1.
  // Without the optional feature the select is tied off so the load path is
  // exactly the addition path.
`ifdef SUMADOR_SERIE_RESTA_EN
  assign resta_sel = resta;
`else
  assign resta_sel = 1'b0;
`endif

  // Full adder on the current LSBs: the first half adder combines the two
  // operand bits, the second folds in the stored carry, and the two partial
  // carries can never both be 1, so an OR gives the majority function.
  medio_sumador u_ha1 (
    .a (reg_a[0]),
    .b (reg_b[0]),
    .s (ha1_s),
    .c (ha1_c)
  );

  medio_sumador u_ha2 (
    .a (ha1_s),
    .b (carry),
    .s (fa_s),
    .c (ha2_c)
  );

  assign fa_c = ha1_c | ha2_c;

  // The serial sum enters at the MSB and drifts right, so after N bits the
  // first (LSB) result bit ends up in position 0. Written as shift-then-set
  // so that the N=1 case needs no special slicing.
  always_comb begin
    sum_next        = sum_reg >> 1;
    sum_next[N-1]   = fa_s;
  end

  // Control and datapath state. REPOSO waits for a start request, SUMA
  // processes one bit per edge and publishes S/Cout on the last bit, and FIN
  // is a single cycle that drives the completion pulse before returning to
  // idle. Start requests outside REPOSO fall through untouched, which is what
  // makes them ignored while busy. S and Cout are only written on the last
  // SUMA edge so the partial serial sum never appears on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= REPOSO;
      reg_a   <= '0;
      reg_b   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      S       <= '0;
      Cout    <= 1'b0;
    end else begin
      case (state)
        REPOSO: begin
          if (inicio) begin
            reg_a <= A;
            reg_b <= resta_sel ? ~B : B;
            carry <= resta_sel;
            cnt   <= '0;
            state <= SUMA;
          end
        end
        SUMA: begin
          reg_a   <= reg_a >> 1;
          reg_b   <= reg_b >> 1;
          sum_reg <= sum_next;
          carry   <= fa_c;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            S     <= sum_next;
            Cout  <= fa_c;
            state <= FIN;
          end
        end
        FIN: begin
          state <= REPOSO;
        end
        default: begin
          state <= REPOSO;
        end
      endcase
    end
  end

  // Status flags come straight from the registered state.
  assign ocupado = (state != REPOSO);
  assign fin     = (state == FIN);

endmodule

// File: tb/tb_sumador_serie.sv
// ---------------------------------------------------------------------------
// tb_sumador_serie -- self-checking bench for sumador_serie (N = 8).
// Table-driven operations plus hand-written sequences for an ignored start
// request, a start during FIN, and an asynchronous reset mid-operation.
// Subtraction vectors run only when SUMADOR_SERIE_RESTA_EN is defined.
// ---------------------------------------------------------------------------
module tb_sumador_serie;

  localparam int N = 8;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       resta;
    logic [7:0] s;
    logic       cout;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         inicio;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         resta;
  logic [N-1:0] S;
  logic         Cout;
  logic         ocupado;
  logic         fin;

  int           checks;
  int           failures;
  logic [7:0]   prev_s;
  vec_t         vecs[7];
  vec_t         rvecs[3];

  sumador_serie #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inicio  (inicio),
    .A       (A),
    .B       (B),
`ifdef SUMADOR_SERIE_RESTA_EN
    .resta   (resta),
`endif
    .S       (S),
    .Cout    (Cout),
    .ocupado (ocupado),
    .fin     (fin)
  );

  // 10-unit clock; inputs are driven and outputs sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Run one operation starting at a falling edge in REPOSO. When inject is
  // set, a competing start with A=B=0xFF is raised after the third bit edge
  // and again during FIN; both must be ignored.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic r, input logic [7:0] es,
                               input logic ec, input bit inject,
                               input string tag);
    int edges;
    A      = a;
    B      = b;
    resta  = r;
    inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    A      = ~a;
    B      = ~b;
    checkOutput({tag, " ocupado_at_E0"}, 32'(ocupado), 32'd1);
    checkOutput({tag, " fin_at_E0"}, 32'(fin), 32'd0);
    edges = 0;
    while (fin !== 1'b1 && edges < 3 * N) begin
      if (inject && edges == 3) begin
        inicio = 1'b1;
        A      = 8'hFF;
        B      = 8'hFF;
      end else begin
        inicio = 1'b0;
      end
      if (edges == N - 1)
        checkOutput({tag, " S_hold_before_done"}, 32'(S), 32'(prev_s));
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    inicio = 1'b0;
    checkOutput({tag, " latency"}, 32'(edges), 32'(N));
    checkOutput({tag, " S"}, 32'(S), 32'(es));
    checkOutput({tag, " Cout"}, 32'(Cout), 32'(ec));
    checkOutput({tag, " ocupado_in_FIN"}, 32'(ocupado), 32'd1);
    prev_s = es;
    if (inject) begin
      inicio = 1'b1;
      A      = 8'hFF;
      B      = 8'hFF;
    end
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    checkOutput({tag, " fin_one_cycle"}, 32'(fin), 32'd0);
    checkOutput({tag, " ocupado_idle"}, 32'(ocupado), 32'd0);
    checkOutput({tag, " S_after"}, 32'(S), 32'(es));
    checkOutput({tag, " Cout_after"}, 32'(Cout), 32'(ec));
  endtask

  initial begin
    int edges;
    bit saw_fin;
    checks   = 0;
    failures = 0;
    prev_s   = 8'h00;
    rst_n    = 1'b0;
    inicio   = 1'b0;
    A        = '0;
    B        = '0;
    resta    = 1'b0;

    vecs[0] = '{a: 8'hA5, b: 8'h5A, resta: 1'b0, s: 8'hFF, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, resta: 1'b0, s: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'h80, b: 8'h80, resta: 1'b0, s: 8'h00, cout: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, resta: 1'b0, s: 8'h00, cout: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, resta: 1'b0, s: 8'hFE, cout: 1'b1};
    vecs[5] = '{a: 8'h55, b: 8'h55, resta: 1'b0, s: 8'hAA, cout: 1'b0};
    vecs[6] = '{a: 8'h3C, b: 8'h0F, resta: 1'b0, s: 8'h4B, cout: 1'b0};

    rvecs[0] = '{a: 8'h05, b: 8'h07, resta: 1'b1, s: 8'hFE, cout: 1'b0};
    rvecs[1] = '{a: 8'h07, b: 8'h05, resta: 1'b1, s: 8'h02, cout: 1'b1};
    rvecs[2] = '{a: 8'h07, b: 8'h05, resta: 1'b0, s: 8'h0C, cout: 1'b0};

    // Reset held for three cycles, then idle with no start request.
    repeat (3) @(negedge clk);
    checkOutput("reset S", 32'(S), 32'h0);
    checkOutput("reset ocupado", 32'(ocupado), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle S", 32'(S), 32'h0);
    checkOutput("idle Cout", 32'(Cout), 32'd0);
    checkOutput("idle ocupado", 32'(ocupado), 32'd0);
    checkOutput("idle fin", 32'(fin), 32'd0);

    // Back-to-back table operations, each started the cycle REPOSO returns.
    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].resta, vecs[i].s,
                    vecs[i].cout, 1'b0, $sformatf("vec%0d", i));

    // Competing start requests during SUMA and FIN must be ignored.
    applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1, "ignore");
    checkOutput("ignore no_restart", 32'(ocupado), 32'd0);

    // Asynchronous reset in the middle of an operation.
    A      = 8'h0F;
    B      = 8'h01;
    inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    for (edges = 0; edges < 4; edges++) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort S", 32'(S), 32'h0);
    checkOutput("abort Cout", 32'(Cout), 32'd0);
    checkOutput("abort ocupado", 32'(ocupado), 32'd0);
    checkOutput("abort fin", 32'(fin), 32'd0);
    saw_fin = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (fin) saw_fin = 1'b1;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (fin) saw_fin = 1'b1;
    end
    checkOutput("abort no_fin", 32'(saw_fin), 32'd0);
    prev_s = 8'h00;
    applyStimulus(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "after_reset");

`ifdef SUMADOR_SERIE_RESTA_EN
    for (int i = 0; i < 3; i++)
      applyStimulus(rvecs[i].a, rvecs[i].b, rvecs[i].resta, rvecs[i].s,
                    rvecs[i].cout, 1'b0, $sformatf("resta%0d", i));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
